// File: rtl/irq_controller_if.sv
// irq_controller_if: pipeline-side bus of the interrupt controller.
// master = pipeline/peripherals, slave = irq_controller.
interface irq_controller_if #(
    parameter int N_IRQ = 4
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             stall;
    logic             int_ack;
    logic             reti;
    logic             interrupt;
    logic [15:0]      vec_addr;
    logic [ID_W-1:0]  active_id;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic             in_service;
    modport master (
        output irq_in, mask_we, mask_wdata, stall, int_ack, reti,
        input  interrupt, vec_addr, active_id, pending, mask, in_service
    );
    modport slave (
        input  irq_in, mask_we, mask_wdata, stall, int_ack, reti,
        output interrupt, vec_addr, active_id, pending, mask, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: synchronises and latches peripheral interrupt edges, masks and
// prioritises them, and runs the request/service handshake with jump-control.
module irq_controller #(
    parameter int          N_IRQ      = 4,
    parameter logic [15:0] VEC_BASE   = 16'hFF00,
    parameter logic [15:0] VEC_STRIDE = 16'd4
) (
    input logic             clk,
    input logic             rst_n,
    irq_controller_if.slave bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d, mask_q, mask_d;
    logic [N_IRQ-1:0] rise, eligible, clr;
    logic [1:0]       state_q, state_d;
    logic             interrupt_q, interrupt_d, in_service_q, in_service_d;
    logic [ID_W-1:0]  id_q, id_d, sel;
    logic [15:0]      vec_q, vec_d;
    logic             take, withdraw;

    assign rise     = sync2_q & ~prev_q;
    assign eligible = pending_q & mask_q;
    assign take     = (state_q == REQ) && bus.int_ack;
    assign withdraw = (state_q == REQ) && bus.mask_we && !bus.mask_wdata[id_q];
    assign clr      = take ? (N_IRQ'(1) << id_q) : '0;
    // A fresh edge on the line being acknowledged outranks the clear.
    assign pending_d = (pending_q & ~clr) | rise;
    assign mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

    // Fixed priority: scanning downwards leaves the lowest eligible index.
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (eligible[i]) sel = ID_W'(i);
    end

    always_comb begin
        state_d      = state_q;
        interrupt_d  = interrupt_q;
        in_service_d = in_service_q;
        id_d         = id_q;
        vec_d        = vec_q;
        case (state_q)
            IDLE: if (|eligible && !bus.stall) begin
                state_d     = REQ;
                interrupt_d = 1'b1;
                id_d        = sel;
                vec_d       = VEC_BASE + VEC_STRIDE * 16'(sel);
            end
            REQ: if (take) begin
                state_d      = SERVICE;
                interrupt_d  = 1'b0;
                in_service_d = 1'b1;
            end else if (withdraw) begin
                state_d     = IDLE;
                interrupt_d = 1'b0;
            end
            SERVICE: if (bus.reti) begin
                state_d      = IDLE;
                in_service_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                interrupt_d  = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            state_q      <= IDLE;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
            id_q         <= '0;
            vec_q        <= VEC_BASE;
        end else begin
            sync1_q      <= bus.irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            interrupt_q  <= interrupt_d;
            in_service_q <= in_service_d;
            id_q         <= id_d;
            vec_q        <= vec_d;
        end
    end

    assign bus.interrupt  = interrupt_q;
    assign bus.in_service = in_service_q;
    assign bus.active_id  = id_q;
    assign bus.vec_addr   = vec_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic, checked against a
// transaction-level model of the controller.
module tb_irq_controller;
    localparam int N = 4;
    localparam logic [27:0] RST_W = {1'b0, 16'hFF00, 2'd0, 4'd0, 4'd0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irq_controller_if #(.N_IRQ(N)) bus();
    irq_controller #(.N_IRQ(N), .VEC_BASE(16'hFF00), .VEC_STRIDE(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int vectors = 0, miscompares = 0;

    // Model: irq samples taken at the last three edges, newest first.
    logic [3:0]  hist[$];
    logic [3:0]  m_pend, m_mask;
    bit          m_req, m_svc;
    int          m_id;
    logic [15:0] m_vec;

    task automatic model_reset();
        hist = '{4'd0, 4'd0, 4'd0};
        m_pend = '0; m_mask = '0; m_req = 0; m_svc = 0; m_id = 0; m_vec = 16'hFF00;
    endtask

    function automatic logic [27:0] exp_w();
        return {m_req, m_vec, 2'(m_id), m_pend, m_mask, m_svc};
    endfunction

    function automatic logic [27:0] dut_w();
        return {bus.interrupt, bus.vec_addr, bus.active_id, bus.pending, bus.mask, bus.in_service};
    endfunction

    // One clock: advance the model from the current inputs, then clear one-shot strobes.
    task automatic step();
        logic [3:0] rise, elig, clr;
        if (!rst_n) model_reset();
        else begin
            rise = hist[1] & ~hist[2];
            elig = m_pend & m_mask;
            clr = '0;
            if (m_req && bus.int_ack) begin
                m_req = 0; m_svc = 1; clr = 4'(1 << m_id);
            end else if (m_req && bus.mask_we && !bus.mask_wdata[m_id]) m_req = 0;
            else if (m_svc && bus.reti) m_svc = 0;
            else if (!m_req && !m_svc && elig != 0 && !bus.stall) begin
                for (int i = 0; i < N; i++) if (elig[i]) begin m_id = i; break; end
                m_vec = 16'hFF00 + 16'(m_id * 4);
                m_req = 1;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (bus.mask_we) m_mask = bus.mask_wdata;
            hist.push_front(bus.irq_in);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        bus.mask_we = 1'b0; bus.int_ack = 1'b0; bus.reti = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        bus.mask_we = 1'b1; bus.mask_wdata = m;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.irq_in = 4'hF;
        for (int k = 0; k < 5; k++) step();
        vectors++;
        if (dut_w() !== RST_W) begin
            miscompares++; $display("FAIL reset_state got=%h exp=%h", dut_w(), RST_W);
        end
        rst_n = 1'b1; bus.irq_in = 4'h0;
        step();
        vectors++;
        if (dut_w() !== exp_w()) begin
            miscompares++; $display("FAIL reset_release got=%h exp=%h", dut_w(), exp_w());
        end
    endtask

    task automatic test_basic();
        write_mask(4'b0001);
        bus.irq_in = 4'b0001;
        for (int k = 0; k < 3; k++) step();
        vectors++;
        if (bus.pending !== 4'b0001 || bus.interrupt !== 1'b0) begin
            miscompares++; $display("FAIL basic_pending_E3 got=%b/%b exp=0001/0", bus.pending, bus.interrupt);
        end
        step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.vec_addr !== 16'hFF00 || bus.active_id !== 2'd0) begin
            miscompares++; $display("FAIL basic_req_E4 got=%b/%h/%0d exp=1/ff00/0", bus.interrupt, bus.vec_addr, bus.active_id);
        end
        bus.int_ack = 1'b1; step();
        vectors++;
        if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0 || bus.in_service !== 1'b1) begin
            miscompares++; $display("FAIL basic_ack got=%b/%b/%b exp=0/0000/1", bus.interrupt, bus.pending, bus.in_service);
        end
        bus.reti = 1'b1; step();
        vectors++;
        if (bus.in_service !== 1'b0 || dut_w() !== exp_w()) begin
            miscompares++; $display("FAIL basic_reti got=%h exp=%h", dut_w(), exp_w());
        end
    endtask

    task automatic test_priority();
        write_mask(4'hF);
        bus.irq_in = 4'b0110;
        for (int k = 0; k < 8 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.active_id !== 2'd1 || bus.vec_addr !== 16'hFF04) begin
            miscompares++; $display("FAIL prio_first got=%b/%0d/%h exp=1/1/ff04", bus.interrupt, bus.active_id, bus.vec_addr);
        end
        bus.int_ack = 1'b1; step();
        bus.reti = 1'b1; step();
        for (int k = 0; k < 3 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.active_id !== 2'd2 || bus.vec_addr !== 16'hFF08) begin
            miscompares++; $display("FAIL prio_second got=%b/%0d/%h exp=1/2/ff08", bus.interrupt, bus.active_id, bus.vec_addr);
        end
        bus.int_ack = 1'b1; step();
        vectors++;
        if (dut_w() !== exp_w()) begin
            miscompares++; $display("FAIL prio_model got=%h exp=%h", dut_w(), exp_w());
        end
    endtask

    task automatic test_no_nesting();
        bus.irq_in = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b1) begin
                miscompares++; $display("FAIL nest_blocked cyc=%0d got=%b/%b exp=0/1", k, bus.interrupt, bus.in_service);
            end
        end
        vectors++;
        if (bus.pending[0] !== 1'b1) begin
            miscompares++; $display("FAIL nest_pending got=%b exp=xxx1", bus.pending);
        end
        bus.reti = 1'b1; step();
        for (int k = 0; k < 3 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.active_id !== 2'd0 || bus.vec_addr !== 16'hFF00) begin
            miscompares++; $display("FAIL nest_after_reti got=%b/%0d/%h exp=1/0/ff00", bus.interrupt, bus.active_id, bus.vec_addr);
        end
        bus.int_ack = 1'b1; step();
        bus.reti = 1'b1; step();
        bus.irq_in = 4'b0000; step();
        bus.stall = 1'b1; bus.irq_in = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (bus.interrupt !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold cyc=%0d got=%b exp=0", k, bus.interrupt);
            end
        end
        bus.stall = 1'b0;
        for (int k = 0; k < 2 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || dut_w() !== exp_w()) begin
            miscompares++; $display("FAIL stall_release got=%h exp=%h", dut_w(), exp_w());
        end
        bus.int_ack = 1'b1; step();
        bus.reti = 1'b1; step();
    endtask

    task automatic test_masking();
        write_mask(4'b0000);
        bus.irq_in = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (bus.interrupt !== 1'b0) begin
                miscompares++; $display("FAIL mask_hold cyc=%0d got=%b exp=0", k, bus.interrupt);
            end
        end
        vectors++;
        if (bus.pending !== 4'b1000) begin
            miscompares++; $display("FAIL mask_pending got=%b exp=1000", bus.pending);
        end
        write_mask(4'b1000);
        for (int k = 0; k < 1 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.vec_addr !== 16'hFF0C || dut_w() !== exp_w()) begin
            miscompares++; $display("FAIL mask_enable got=%h exp=%h", dut_w(), exp_w());
        end
        bus.int_ack = 1'b1; step();
        bus.reti = 1'b1; step();
    endtask

    task automatic test_withdraw_reset();
        bus.irq_in = 4'b0000;
        write_mask(4'hF);
        step(); step();
        bus.irq_in = 4'b0010;
        for (int k = 0; k < 8 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.active_id !== 2'd1) begin
            miscompares++; $display("FAIL wd_req got=%b/%0d exp=1/1", bus.interrupt, bus.active_id);
        end
        write_mask(4'b0000);
        vectors++;
        if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0010 || dut_w() !== exp_w()) begin
            miscompares++; $display("FAIL wd_withdraw got=%h exp=%h", dut_w(), exp_w());
        end
        write_mask(4'hF);
        for (int k = 0; k < 2 && !bus.interrupt; k++) step();
        vectors++;
        if (bus.interrupt !== 1'b1 || bus.vec_addr !== 16'hFF04) begin
            miscompares++; $display("FAIL wd_reenable got=%b/%h exp=1/ff04", bus.interrupt, bus.vec_addr);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_w() !== RST_W) begin
            miscompares++; $display("FAIL async_reset got=%h exp=%h", dut_w(), RST_W);
        end
        step();
        rst_n = 1'b1; bus.irq_in = 4'b0000;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) bus.irq_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                bus.mask_we = 1'b1; bus.mask_wdata = 4'($urandom);
            end
            bus.stall   = ($urandom_range(0, 3) == 0);
            bus.int_ack = ($urandom_range(0, 2) == 0);
            bus.reti    = ($urandom_range(0, 3) == 0);
            step();
            vectors++;
            if (dut_w() !== exp_w()) begin
                miscompares++; $display("FAIL random cyc=%0d got=%h exp=%h", k, dut_w(), exp_w());
            end
        end
    endtask

    initial begin
        bus.irq_in = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
        bus.stall = 1'b0; bus.int_ack = 1'b0; bus.reti = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_no_nesting();
        test_masking();
        test_withdraw_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller feeding the single `interrupt` input of the pipeline's jump-control block.
- Synchronises N peripheral interrupt lines and latches rising edges as pending.
- Applies a software-written enable mask, selects the highest-priority request, and drives the vector address and request handshake.
- Blocks further requests until the pipeline signals return-from-interrupt (RETI).

Parameters:
- N_IRQ, 4, number of interrupt lines (2..16). ID_W = clog2(N_IRQ), derived.
- VEC_BASE, 16'hFF00, vector address of line 0.
- VEC_STRIDE, 16'd4, address distance between consecutive line vectors.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  N_IRQ  peripheral interrupt lines, asynchronous to clk.
- mask_we  in  1  one-cycle write strobe for the enable mask (EX stage).
- mask_wdata  in  N_IRQ  new mask value; bit=1 enables the line.
- stall  in  1  pipeline stall; a new request must not start while high.
- int_ack  in  1  one-cycle pulse; jump-control has taken the jump to vec_addr.
- reti  in  1  one-cycle pulse; the RETI instruction has retired.
- interrupt  out  1  request to jump-control.
- vec_addr  out  16  jump target for the current request.
- active_id  out  ID_W  line currently requested or in service.
- pending  out  N_IRQ  latched edge-pending bits.
- mask  out  N_IRQ  current enable mask.
- in_service  out  1  handler executing.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, interrupt=0, in_service=0, pending=0, mask=0, active_id=0, vec_addr=VEC_BASE, synchroniser and edge flops=0.
- Synchronisation:
  - Each irq_in bit passes through a 2-flop synchroniser, then a previous-value flop.
  - edge[i] = sync2[i] & ~prev[i].
  - Edge-to-pending latency: irq_in high at sampling edge E1 gives pending[i]=1 after edge E3.
- pending[i]:
  - Set on edge[i] regardless of mask.
  - Cleared on the int_ack that accepts line i.
  - If set and clear coincide, set wins and the line stays pending.
- Mask:
  - mask_we writes mask at the clock edge.
  - The new value is used for selection from the following cycle.
- Selection:
  - eligible = pending & mask.
  - Lowest index has highest priority; fixed priority.
- FSM states: IDLE, REQ, SERVICE. All outputs are registered.
- IDLE:
  - If eligible != 0 and stall == 0: go to REQ. Latch active_id = lowest eligible index and vec_addr = VEC_BASE + active_id*VEC_STRIDE (mod 2^16).
  - interrupt=1 from the same edge.
- REQ:
  - interrupt held at 1. active_id and vec_addr held stable; there is no preemption by later higher-priority lines.
  - int_ack: go to SERVICE, clear pending[active_id], interrupt=0, in_service=1.
  - Mask bit of active_id cleared (mask_we) with no int_ack that cycle: return to IDLE, interrupt=0, pending retained.
  - int_ack and a masking write in the same cycle: int_ack wins.
- SERVICE:
  - interrupt=0. New edges still set pending, but no request is issued (no nesting).
  - reti: go to IDLE, in_service=0.
  - From IDLE, a new request can issue on the next edge.
- Ignored inputs: int_ack outside REQ; reti outside SERVICE.
- Reset mid-operation: all state is cleared immediately. interrupt drops combinationally through the async flop reset. Pending requests are lost.

Test Plan:
1. Reset: hold reset=0 with irq_in=4'hF for 5 cycles.
   - Required: interrupt=0, pending=0, mask=0, vec_addr=16'hFF00, in_service=0.
2. Basic flow: release reset, write mask=4'b0001, raise irq_in[0] at edge E1.
   - After E3: pending=4'b0001.
   - After E4: interrupt=1, vec_addr=16'hFF00, active_id=0.
   - int_ack pulse: interrupt=0, pending=0, in_service=1.
   - reti pulse: in_service=0.
3. Priority: mask=4'hF, raise irq_in[1] and irq_in[2] together.
   - First request: active_id=1, vec_addr=16'hFF04.
   - After ack and reti: active_id=2, vec_addr=16'hFF08.
4. Masking: mask=0, raise irq_in[3].
   - pending=4'b1000 and interrupt stays 0 for 10 cycles.
   - Write mask=4'b1000: interrupt=1 within 2 cycles, vec_addr=16'hFF0C.
5. No nesting, no preemption, stall gating:
   - In SERVICE on line 2, raise irq_in[0]: pending[0]=1, interrupt stays 0 until reti, then active_id=0.
   - With stall=1 and eligible != 0: interrupt stays 0 until stall drops.
6. Withdraw and reset mid-operation:
   - In REQ on line 1, write mask=0: interrupt=0 next cycle, pending[1] still 1.
   - Re-enable, then assert reset=0 mid-REQ: all outputs return to reset values asynchronously.
